// File: rtl/ysyx_23060208_axi_pkg.sv
// Shared AXI4 definitions for the SoC-side slaves and the core interconnect.
// Latency: n/a (types, widths and a pure address-step function only).
// Backpressure: n/a.
package ysyx_23060208_axi_pkg;

    localparam int ID_W   = 4;
    localparam int LEN_W  = 8;
    localparam int SIZE_W = 3;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } r_state_e;

    // Address of the next beat. FIXED holds; everything else steps as INCR
    // (WRAP/reserved bursts are errored by the slave, so the step is moot).
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [SIZE_W-1:0] size,
                                                    input logic [1:0]        burst);
        logic [ADDR_W-1:0] step;
        step = ADDR_W'(1) << size;
        if (burst == BURST_FIXED) begin
            return addr;
        end
        return (addr & ~(step - ADDR_W'(1))) + step;
    endfunction

endpackage

// File: rtl/ysyx_23060208_axi_sram_if.sv
// AXI4 bus bundle (AW/W/B/AR/R) between the interconnect and the SRAM slave.
// Latency: n/a (wires only).
// Backpressure: plain AXI valid/ready on every channel.
interface ysyx_23060208_axi_sram_if;
    import ysyx_23060208_axi_pkg::*;

    logic              awready;
    logic              awvalid;
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [LEN_W-1:0]  awlen;
    logic [SIZE_W-1:0] awsize;
    logic [1:0]        awburst;

    logic              wready;
    logic              wvalid;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              wlast;

    logic              bready;
    logic              bvalid;
    logic [1:0]        bresp;
    logic [ID_W-1:0]   bid;

    logic              arready;
    logic              arvalid;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [LEN_W-1:0]  arlen;
    logic [SIZE_W-1:0] arsize;
    logic [1:0]        arburst;

    logic              rready;
    logic              rvalid;
    logic [1:0]        rresp;
    logic [63:0]       rdata;
    logic              rlast;
    logic [ID_W-1:0]   rid;

    modport master (
        input  awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rdata, rlast, rid,
        output awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast,
               bready, arvalid, araddr, arid, arlen, arsize, arburst, rready
    );

    modport slave (
        output awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rdata, rlast, rid,
        input  awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast,
               bready, arvalid, araddr, arid, arlen, arsize, arburst, rready
    );

endinterface

// File: rtl/ysyx_23060208_sram_array.sv
// 1R1W word array with per-byte write enables and a registered read port.
// Latency: read data appears one cycle after rd_en; a same-cycle write to the read word returns old data.
// Backpressure: none; rd_dat holds its value while rd_en is low.
// Ports: clock; wr_en/wr_idx/wr_dat/wr_strb write port; rd_en/rd_idx/rd_dat read port.
module ysyx_23060208_sram_array #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DW         = 64
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [DW-1:0]         wr_dat,
    input  logic [DW/8-1:0]       wr_strb,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [DW-1:0]         rd_dat
);

    logic [DW-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_dat <= mem[rd_idx];
        end
        if (wr_en) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ysyx_23060208_axi_sram.sv
// AXI4 SRAM slave with independent read and write FSMs, INCR/FIXED bursts, narrow sizes, strobes.
// Latency: rvalid READ_LATENCY cycles after the AR handshake, then one beat per cycle; bvalid the cycle after the last W beat.
// Backpressure: R outputs hold while rvalid&~rready; one outstanding burst per channel (awready/arready low while busy).
// Ports: clock, reset (async, active-high), bus (slave modport of the AXI bundle).
module ysyx_23060208_axi_sram
    import ysyx_23060208_axi_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h0f00_0000,
    parameter int          DEPTH_LOG2   = 10,
    parameter int          READ_LATENCY = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    ysyx_23060208_axi_sram_if.slave    bus
);

    localparam int          BUS_W = 2 * DATA_WIDTH;
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd8 << DEPTH_LOG2);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
    endfunction

    function automatic logic cfg_ok(input logic [SIZE_W-1:0] size, input logic [1:0] burst);
        return (size <= 3'd3) && (burst == BURST_FIXED || burst == BURST_INCR);
    endfunction

    // Ready strobes stay low until the first edge after reset releases.
    logic ready_en;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) ready_en <= 1'b0;
        else       ready_en <= 1'b1;
    end

    // ---------------- write channel ----------------
    w_state_e          w_state, w_state_nxt;
    logic [ADDR_W-1:0] w_addr;
    logic [ID_W-1:0]   w_id;
    logic [LEN_W-1:0]  w_len, w_cnt;
    logic [SIZE_W-1:0] w_size;
    logic [1:0]        w_burst, w_err, w_beat_err;
    logic              w_beat, w_mem_en;

    always_comb begin
        w_state_nxt = w_state;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bid     = '0;
        bus.bresp   = RESP_OKAY;
        w_beat      = 1'b0;
        case (w_state)
            W_IDLE: begin
                bus.awready = ready_en;
                if (bus.awvalid && ready_en) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                bus.wready = 1'b1;
                if (bus.wvalid) begin
                    w_beat = 1'b1;
                    if (w_cnt == w_len) w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                bus.bvalid = 1'b1;
                bus.bid    = w_id;
                bus.bresp  = w_err;
                if (bus.bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Per-beat error; the sticky register keeps only the first one seen.
    always_comb begin
        w_beat_err = RESP_OKAY;
        if (!cfg_ok(w_size, w_burst) || (bus.wlast != (w_cnt == w_len))) w_beat_err = RESP_SLVERR;
        else if (!in_range(w_addr))                                       w_beat_err = RESP_DECERR;
    end

    assign w_mem_en = w_beat && cfg_ok(w_size, w_burst) && in_range(w_addr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_id    <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= RESP_OKAY;
        end else begin
            w_state <= w_state_nxt;
            if (bus.awvalid && bus.awready) begin
                w_addr  <= bus.awaddr;
                w_id    <= bus.awid;
                w_len   <= bus.awlen;
                w_size  <= bus.awsize;
                w_burst <= bus.awburst;
                w_cnt   <= '0;
                w_err   <= RESP_OKAY;
            end
            if (w_beat) begin
                w_addr <= next_addr(w_addr, w_size, w_burst);
                w_cnt  <= w_cnt + 8'd1;
                if (w_err == RESP_OKAY) w_err <= w_beat_err;
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_e              r_state, r_state_nxt;
    logic [ADDR_W-1:0]     r_addr;
    logic [ID_W-1:0]       r_id;
    logic [LEN_W-1:0]      r_len, r_cnt;
    logic [SIZE_W-1:0]     r_size;
    logic [1:0]            r_burst, r_beat_resp;
    logic [7:0]            r_lat;
    logic                  rd_en;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [ADDR_W-1:0]     r_addr_nxt;
    logic [BUS_W-1:0]      arr_q;

    assign r_addr_nxt = next_addr(r_addr, r_size, r_burst);

    always_comb begin
        r_beat_resp = RESP_OKAY;
        if (!cfg_ok(r_size, r_burst)) r_beat_resp = RESP_SLVERR;
        else if (!in_range(r_addr))   r_beat_resp = RESP_DECERR;
    end

    // The array is read on the edge that accepts a beat, so the next beat's
    // word is registered by the following cycle; a stall issues no read and
    // the array output simply holds.
    always_comb begin
        r_state_nxt = r_state;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rid     = '0;
        bus.rresp   = RESP_OKAY;
        bus.rlast   = 1'b0;
        bus.rdata   = '0;
        rd_en       = 1'b0;
        rd_idx      = bus.araddr[DEPTH_LOG2+2:3];
        case (r_state)
            R_IDLE: begin
                bus.arready = ready_en;
                if (bus.arvalid && ready_en) begin
                    rd_en       = cfg_ok(bus.arsize, bus.arburst);
                    r_state_nxt = (READ_LATENCY <= 1) ? R_DATA : R_WAIT;
                end
            end
            R_WAIT: begin
                // Leaving on count 1 makes the R_DATA entry edge the last latency cycle.
                if (r_lat <= 8'd1) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                bus.rvalid = 1'b1;
                bus.rid    = r_id;
                bus.rlast  = (r_cnt == r_len);
                bus.rresp  = r_beat_resp;
                bus.rdata  = (r_beat_resp == RESP_OKAY) ? arr_q : '0;
                if (bus.rready) begin
                    if (r_cnt == r_len) begin
                        r_state_nxt = R_IDLE;
                    end else begin
                        rd_en  = cfg_ok(r_size, r_burst);
                        rd_idx = r_addr_nxt[DEPTH_LOG2+2:3];
                    end
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_lat   <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (bus.arvalid && bus.arready) begin
                r_addr  <= bus.araddr;
                r_id    <= bus.arid;
                r_len   <= bus.arlen;
                r_size  <= bus.arsize;
                r_burst <= bus.arburst;
                r_cnt   <= '0;
                r_lat   <= 8'(READ_LATENCY - 1);
            end else if (r_state == R_WAIT && r_lat != 8'd0) begin
                r_lat <= r_lat - 8'd1;
            end
            if (bus.rvalid && bus.rready) begin
                r_addr <= r_addr_nxt;
                r_cnt  <= r_cnt + 8'd1;
            end
        end
    end

    ysyx_23060208_sram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DW         (BUS_W)
    ) u_array (
        .clock   (clock),
        .wr_en   (w_mem_en),
        .wr_idx  (w_addr[DEPTH_LOG2+2:3]),
        .wr_dat  (bus.wdata),
        .wr_strb (bus.wstrb),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_dat  (arr_q)
    );

endmodule

// File: tb/tb_ysyx_23060208_axi_sram.sv
// Directed bench for the AXI SRAM slave: reference memory model plus read/write scoreboards.
module tb_ysyx_23060208_axi_sram;
    import ysyx_23060208_axi_pkg::*;

    localparam logic [31:0] BASE = 32'h0f00_0000;
    localparam logic [31:0] SPAN = 32'h0000_2000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ysyx_23060208_axi_sram_if bus();

    ysyx_23060208_axi_sram #(
        .DATA_WIDTH   (32),
        .BASE_ADDR    (BASE),
        .DEPTH_LOG2   (10),
        .READ_LATENCY (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed { logic [63:0] dat; logic [1:0] resp; logic last; } rexp_t;
    typedef struct packed { logic [3:0] id; logic [1:0] resp; } bexp_t;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] mdl [1024];
    rexp_t       rq [$];
    bexp_t       bq [$];
    logic [63:0] wd [16];
    logic [7:0]  ws [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_inr(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + SPAN);
    endfunction

    function automatic logic m_ok(input logic [2:0] size, input logic [1:0] burst);
        return (size < 3'd4) && (burst < 2'd2);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step;
        step = 32'd1 << size;
        if (burst == 2'd0) return a;
        return (a / step) * step + step;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int early);
        logic [31:0] a;
        logic [1:0]  err;
        logic        lst;
        bexp_t       e;
        int          n;
        a   = addr;
        err = 2'd0;
        for (int i = 0; i <= len; i++) begin
            lst = (i == len) || (i == early);
            if (err == 2'd0) begin
                if (!m_ok(size, burst) || (lst != (i == len))) err = 2'd2;
                else if (!m_inr(a))                            err = 2'd3;
            end
            if (m_ok(size, burst) && m_inr(a)) begin
                for (int b = 0; b < 8; b++) begin
                    if (ws[i][b]) mdl[(a - BASE) >> 3][b*8 +: 8] = wd[i][b*8 +: 8];
                end
            end
            a = m_next(a, size, burst);
        end
        bq.push_back('{id: id, resp: err});

        bus.awaddr  = addr;
        bus.awid    = id;
        bus.awlen   = len[7:0];
        bus.awsize  = size;
        bus.awburst = burst;
        bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 50) begin @(negedge clock); n++; end
        chk("aw_accept", bus.awready, 1);
        @(negedge clock);
        bus.awvalid = 1'b0;

        for (int i = 0; i <= len; i++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = wd[i];
            bus.wstrb  = ws[i];
            bus.wlast  = (i == len) || (i == early);
            n = 0;
            while (!bus.wready && n < 50) begin @(negedge clock); n++; end
            chk("w_accept", bus.wready, 1);
            @(negedge clock);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;

        bus.bready = 1'b1;
        n = 0;
        while (!bus.bvalid && n < 50) begin @(negedge clock); n++; end
        chk("b_valid", bus.bvalid, 1);
        e = bq.pop_front();
        chk("b_id", bus.bid, e.id);
        chk("b_resp", bus.bresp, e.resp);
        @(negedge clock);
        bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [3:0] pat);
        logic [31:0] a;
        logic [1:0]  r;
        rexp_t       e;
        logic        stalled;
        logic [63:0] h_dat;
        logic [2:0]  h_ctl;
        int          n, got, cyc;
        a = addr;
        for (int i = 0; i <= len; i++) begin
            r = !m_ok(size, burst) ? 2'd2 : (!m_inr(a) ? 2'd3 : 2'd0);
            rq.push_back('{dat: (r == 2'd0) ? mdl[(a - BASE) >> 3] : 64'd0, resp: r, last: (i == len)});
            a = m_next(a, size, burst);
        end

        bus.araddr  = addr;
        bus.arid    = id;
        bus.arlen   = len[7:0];
        bus.arsize  = size;
        bus.arburst = burst;
        bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 50) begin @(negedge clock); n++; end
        chk("ar_accept", bus.arready, 1);
        @(negedge clock);
        bus.arvalid = 1'b0;
        chk("r_latency", bus.rvalid, 1);

        got     = 0;
        cyc     = 0;
        stalled = 1'b0;
        h_dat   = '0;
        h_ctl   = '0;
        while (got <= len && cyc < 200) begin
            bus.rready = pat[cyc % 4];
            if (bus.rvalid) begin
                if (stalled) begin
                    chk("r_hold_dat", bus.rdata, h_dat);
                    chk("r_hold_ctl", {bus.rresp, bus.rlast}, h_ctl);
                end
                if (bus.rready) begin
                    e = rq.pop_front();
                    chk("r_dat", bus.rdata, e.dat);
                    chk("r_resp", bus.rresp, e.resp);
                    chk("r_last", bus.rlast, e.last);
                    chk("r_id", bus.rid, id);
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    h_dat   = bus.rdata;
                    h_ctl   = {bus.rresp, bus.rlast};
                end
            end
            @(negedge clock);
            cyc++;
        end
        bus.rready = 1'b0;
        chk("r_beats", got, len + 1);
        chk("r_idle_after", bus.rvalid, 0);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk(tag, {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast,
                  bus.bresp, bus.rresp, bus.bid, bus.rid}, 0);
        chk({tag, "_rdata"}, bus.rdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.rready = 0;

        // Power-on reset
        repeat (3) @(negedge clock);
        chk_outs_zero("rst_outs");
        reset = 1'b0;
        #1;
        chk("rst_ready_pre", {bus.awready, bus.arready}, 2'b00);
        @(negedge clock);
        chk("rst_ready_post", {bus.awready, bus.arready}, 2'b11);

        // Reset in the middle of a write burst
        bus.awaddr = BASE + 32'h800; bus.awid = 4'h1; bus.awlen = 8'd3; bus.awsize = 3'd3;
        bus.awburst = 2'd1; bus.awvalid = 1'b1;
        @(negedge clock);
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b1; bus.wdata = 64'h0123; bus.wstrb = 8'hFF; bus.wlast = 1'b0;
        repeat (2) @(negedge clock);
        chk("mid_wready", bus.wready, 1);
        reset = 1'b1;
        #1;
        chk_outs_zero("midrst_outs");
        bus.wvalid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_ready", {bus.awready, bus.arready}, 2'b11);

        // Single write then read
        wd[0] = 64'h1122_3344_5566_7788; ws[0] = 8'hFF;
        do_write(BASE + 32'h8, 4'h5, 0, 3'd3, 2'd1, -1);
        do_read(BASE + 32'h8, 4'h3, 0, 3'd3, 2'd1, 4'b1111);

        // INCR burst, partial strobe on beat 2, then a stalled read
        for (int i = 0; i < 4; i++) begin
            wd[i] = {32'hAAAA_0000 + 32'(i), 32'h5555_0000 + 32'(i)};
            ws[i] = 8'hFF;
        end
        do_write(BASE + 32'h100, 4'h2, 3, 3'd3, 2'd1, -1);
        for (int i = 0; i < 4; i++) begin
            wd[i] = {32'hBBBB_0000 + 32'(i), 32'hCCCC_0000 + 32'(i)};
            ws[i] = (i == 2) ? 8'h0F : 8'hFF;
        end
        do_write(BASE + 32'h100, 4'h4, 3, 3'd3, 2'd1, -1);
        do_read(BASE + 32'h100, 4'h8, 3, 3'd3, 2'd1, 4'b0101);

        // Narrow INCR write at 0x04 then 0x08
        wd[0] = 64'hDEAD_BEEF_0BAD_F00D; ws[0] = 8'hFF;
        do_write(BASE, 4'h6, 0, 3'd3, 2'd1, -1);
        wd[0] = 64'h4444_4444_0000_0000; ws[0] = 8'hF0;
        wd[1] = 64'h0000_0000_9999_9999; ws[1] = 8'h0F;
        do_write(BASE + 32'h4, 4'h7, 1, 3'd2, 2'd1, -1);
        do_read(BASE, 4'h1, 1, 3'd3, 2'd1, 4'b1111);
        do_read(BASE + 32'h4, 4'h2, 1, 3'd2, 2'd1, 4'b1111);

        // FIXED read returns the same word each beat
        do_read(BASE + 32'h100, 4'hA, 2, 3'd3, 2'd0, 4'b1111);

        // Burst crossing the top of the window
        wd[0] = 64'hFEED_FACE_CAFE_0001; ws[0] = 8'hFF;
        do_write(BASE + 32'h1FF8, 4'hB, 0, 3'd3, 2'd1, -1);
        do_read(BASE + 32'h1FF8, 4'hC, 1, 3'd3, 2'd1, 4'b1111);

        // WRAP write is rejected and leaves memory alone
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        do_write(BASE + 32'h8, 4'hD, 0, 3'd3, 2'd2, -1);
        do_read(BASE + 32'h8, 4'hE, 0, 3'd3, 2'd1, 4'b1111);

        // Early wlast
        for (int i = 0; i < 4; i++) begin
            wd[i] = 64'h2000_0000 + 64'(i); ws[i] = 8'hFF;
        end
        do_write(BASE + 32'h200, 4'h9, 3, 3'd3, 2'd1, 1);

        // Oversized beat
        do_read(BASE + 32'h8, 4'h1, 0, 3'd4, 2'd1, 4'b1111);

        // Concurrent read and write bursts
        for (int i = 0; i < 8; i++) begin
            wd[i] = {32'h4000_0000 + 32'(i), 32'h0400_0000 + 32'(i)}; ws[i] = 8'hFF;
        end
        do_write(BASE + 32'h400, 4'h3, 7, 3'd3, 2'd1, -1);
        for (int i = 0; i < 8; i++) begin
            wd[i] = {32'h3000_0000 + 32'(i), 32'h0300_0000 + 32'(i)}; ws[i] = 8'hFF;
        end
        fork
            do_write(BASE + 32'h300, 4'h2, 7, 3'd3, 2'd1, -1);
            do_read(BASE + 32'h400, 4'h6, 7, 3'd3, 2'd1, 4'b1111);
        join
        do_read(BASE + 32'h300, 4'h5, 7, 3'd3, 2'd1, 4'b0101);
        do_read(BASE + 32'h100, 4'h7, 3, 3'd3, 2'd1, 4'b1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
